mux_4x1: RTL and testbench

MUX_4X1 -- requirements
Module: mux_4x1

---
 rtl/mux_4x1.sv | 45 ++++
 tb/tb_mux_4x1.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/mux_4x1.sv
// Registered 4:1 multiplexer: Y loads the input picked by {S1,S0} on each rising clock edge.
// Y comes only from the register, so no input has a combinational path to the output.
module mux_4x1 #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] I0,
  input  logic [WIDTH-1:0] I1,
  input  logic [WIDTH-1:0] I2,
  input  logic [WIDTH-1:0] I3,
  input  logic             S1,
  input  logic             S0,
  output logic [WIDTH-1:0] Y
);

  logic [1:0]       sel;
  logic [WIDTH-1:0] y_d;
  logic [WIDTH-1:0] y_q;

  assign sel = {S1, S0};

  // A plain case matches exactly, so an X or Z select falls through to the default and loads zeros.
  always_comb begin
    y_d = '0;
    case (sel)
      2'b00:   y_d = I0;
      2'b01:   y_d = I1;
      2'b10:   y_d = I2;
      2'b11:   y_d = I3;
      default: y_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q <= '0;
    end else begin
      y_q <= y_d;
    end
  end

  assign Y = y_q;

endmodule

// File: tb/tb_mux_4x1.sv
// Directed bench for mux_4x1 (WIDTH=8): expected outputs are queued when stimulus is
// driven and popped one clock later when the registered output is sampled.
module tb_mux_4x1;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] i0, i1, i2, i3;
  logic         s1, s0;
  logic [W-1:0] y;

  int unsigned  n_cmp;
  int unsigned  n_bad;
  logic [W-1:0] exp_q[$];

  mux_4x1 #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .I0   (i0),
    .I1   (i1),
    .I2   (i2),
    .I3   (i3),
    .S1   (s1),
    .S0   (s0),
    .Y    (y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] model(input logic [1:0] s, input logic [W-1:0] a,
                                         input logic [W-1:0] b, input logic [W-1:0] c,
                                         input logic [W-1:0] d);
    case (s)
      2'd0:    return a;
      2'd1:    return b;
      2'd2:    return c;
      default: return d;
    endcase
  endfunction

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Drive on the falling edge and queue what the next rising edge must load.
  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c,
                       input logic [W-1:0] d, input logic [1:0] s);
    @(negedge clk);
    i0 = a; i1 = b; i2 = c; i3 = d;
    {s1, s0} = s;
    exp_q.push_back(model(s, a, b, c, d));
  endtask

  task automatic sample(input string tag);
    logic [W-1:0] e;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $error("FAIL %s observed=%h expected=<queued value> (scoreboard empty)", tag, y);
    end else begin
      e = exp_q.pop_front();
      check(tag, y, e);
    end
  endtask

  initial begin
    logic [W-1:0] t3;
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b1;
    i0 = 8'h00; i1 = 8'h01; i2 = 8'h00; i3 = 8'h01;
    {s1, s0} = 2'b11;
    #2 rst_n = 1'b0;
    #1 check("reset_immediate", y, 8'h00);

    // Clock edges are ignored while reset is held, even with a non-zero input selected.
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1 check("reset_hold", y, 8'h00);
    end

    // Release between edges; the first edge afterwards loads the selected input.
    @(negedge clk);
    rst_n = 1'b1;
    drive(8'h00, 8'h01, 8'h00, 8'h01, 2'b00); sample("sweep_00");
    drive(8'h00, 8'h01, 8'h00, 8'h01, 2'b01); sample("sweep_01");
    drive(8'h00, 8'h01, 8'h00, 8'h01, 2'b10); sample("sweep_10");
    drive(8'h00, 8'h01, 8'h00, 8'h01, 2'b11); sample("sweep_11");

    // Mid-cycle select change must not reach Y until the next rising edge.
    drive(8'h00, 8'h01, 8'h00, 8'h01, 2'b00); sample("hold_base");
    drive(8'h00, 8'h01, 8'h00, 8'h01, 2'b01);
    #1 check("hold_between_edges", y, 8'h00);
    i2 = 8'hAA; i3 = 8'h55;
    #1 check("hold_data_change", y, 8'h00);
    sample("hold_after_edge");

    // Select 11 with I3 toggling; the other inputs are noise.
    t3 = 8'h00;
    for (int k = 0; k < 8; k++) begin
      t3 = ~t3 & 8'h01;
      drive(8'($urandom), 8'($urandom), 8'($urandom), t3, 2'b11);
      sample("track_i3");
    end

    // Full-width selection.
    drive(8'h11, 8'h22, 8'h33, 8'h44, 2'b00); sample("width_00");
    drive(8'h11, 8'h22, 8'h33, 8'h44, 2'b01); sample("width_01");
    drive(8'h11, 8'h22, 8'h33, 8'h44, 2'b10); sample("width_10");
    drive(8'h11, 8'h22, 8'h33, 8'h44, 2'b11); sample("width_11");

    // Select and data change on the same edge: new select with its new data.
    drive(8'h11, 8'h22, 8'hC3, 8'h44, 2'b10); sample("same_edge_change");
    drive(8'hF0, 8'h0F, 8'h5A, 8'hA5, 2'b01); sample("mixed_bits");

    // Asynchronous reset pulse between edges with Y=1.
    drive(8'h00, 8'h01, 8'h00, 8'h01, 2'b11); sample("pre_async_reset");
    #2 rst_n = 1'b0;
    #1 check("async_reset_immediate", y, 8'h00);
    @(posedge clk);
    #1 check("async_reset_ignores_edge", y, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("async_release_before_edge", y, 8'h00);
    exp_q.push_back(model({s1, s0}, i0, i1, i2, i3));
    sample("async_reload");

    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $error("FAIL scoreboard_drain observed=%0d leftover expected=0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
